rpn_display_ctrl: RTL and testbench
===================================

Name: rpn_display_ctrl

Overview:
- Sequencing controller for the 3-digit result display of the 8-bit RPN ALU.
- Latches the ALU result on a valid strobe and holds it stable for the display converters.
- Drives the 2-bit base select (00 = Dec, 01 = Hex, 10 = Oct) from a debounced pushbutton, or from an auto-rotate timer.
- Generates a blink/blank signal while an overflow is latched. Sits between the ALU output and the display path (converters plus 3:1 segment muxes).

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a button level (10 ms at 50 MHz)
AUTO_PERIOD, 50000000, cycles between automatic base advances in auto mode (1 s)
BLINK_PERIOD, 25000000, cycles per half-period of the overflow blink (0.5 s)

Ports:
Clock  input  1  system clock, single clock domain
Resetn  input  1  asynchronous reset, active-low
Resultado  input  8  ALU result
ResultadoValido  input  1  one-cycle strobe: Resultado/Overflow are valid this cycle
Overflow  input  1  ALU overflow/carry flag, qualified by ResultadoValido
BotaoBase  input  1  raw base pushbutton, active-low (pressed = 0), asynchronous to Clock
ModoAuto  input  1  raw slide switch, 1 = auto-rotate base, asynchronous to Clock
ResultadoLatched  output  8  held result feeding the display converters
Base  output  2  base select to the display muxes
BaseLed  output  3  one-hot base indicator: [0] = Dec, [1] = Hex, [2] = Oct
Blank  output  1  1 = display path forces all segments off

Behaviour:

Reset (Resetn = 0, asynchronous):
- ResultadoLatched = 0, Base = 00, BaseLed = 001, Blank = 0.
- Overflow latch = 0; all counters = 0; synchronizers and debounced level = 1 (released).

Input conditioning:
- BotaoBase and ModoAuto each pass through a 2-flop synchronizer.
- BotaoBase is then debounced. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free sample resets the counter.
- Press event: a one-cycle pulse when the debounced level goes 1 -> 0.
- Latency from a stable raw press to the pulse is 2 + DEBOUNCE_CYCLES cycles, +/-1.
- Release produces no event. Bounces shorter than DEBOUNCE_CYCLES produce no event.
- ModoAuto is synchronized only; it is not debounced.

Base FSM (states DEC = 00, HEX = 01, OCT = 10):
- Advance order: DEC -> HEX -> OCT -> DEC.
- An advance occurs on (press event) OR (auto tick). Both in the same cycle = exactly one advance.
- Base is registered: it updates the cycle after the event. BaseLed is decoded from the Base register.
- Base = 11 is never produced. If the state register ever reaches 11, the next cycle forces DEC.

Auto timer:
- Counts only while synchronized ModoAuto = 1.
- Auto tick when the count reaches AUTO_PERIOD - 1; the count then wraps to 0.
- The counter clears to 0 when ModoAuto = 0 and on every press event, so manual presses restart the full period.

Result latch:
- When ResultadoValido = 1: ResultadoLatched <= Resultado and the overflow latch <= Overflow, on the next edge.
- Latency is 1 cycle. Otherwise both hold.
- A strobe in the same cycle as a base advance: both take effect; they are independent.

Blink:
- While the overflow latch = 1, a blink counter runs and Blank toggles every BLINK_PERIOD cycles. Blank goes 1 first, BLINK_PERIOD cycles after the latch sets.
- A strobe with Overflow = 0 clears the latch and the counter, and Blank = 0 on the next cycle.
- A new strobe with Overflow = 1 while already blinking restarts the blink counter.
- Blank = 0 whenever the latch = 0.

Reset mid-operation:
- Any in-progress debounce, auto count or blink is discarded; all outputs return to their reset values immediately.

Decomposition:
- Shared include/constants file: base encodings BASE_DEC = 2'b00, BASE_HEX = 2'b01, BASE_OCT = 2'b10. The display muxes use the same file.
- One sub-module: rpn_debounce.
  - Ports: Clock, Resetn, raw in, debounced level out, falling-edge pulse out.
  - Contains the 2-flop synchronizer; parameter DEBOUNCE_CYCLES.
- The FSM, auto timer, result latch and blink logic stay in the top module.

Test Plan (DEBOUNCE_CYCLES = 4, AUTO_PERIOD = 10, BLINK_PERIOD = 3):
1. Reset, then hold Resetn = 0 mid-count -> Base = 00, BaseLed = 001, Blank = 0, ResultadoLatched = 0 immediately, asynchronously.
2. Three clean presses, each held 8 cycles with 8-cycle gaps -> Base goes 01, 10, 00; each change 6-7 cycles after the press edge.
3. Press with 2-cycle bounces (0,1,0,1 then steady 0) -> exactly one advance, 00 -> 01; a 3-cycle glitch alone -> no change.
4. ModoAuto = 1 for 35 cycles -> three advances, 10 cycles apart: 00 -> 01 -> 10 -> 00. A press event coinciding with a tick -> a single advance, and the next tick comes 10 cycles later.
5. Strobe Resultado = 8'hC8 with Overflow = 1 -> ResultadoLatched = 8'hC8 next cycle, then Blank toggles 1/0 every 3 cycles. Strobe 8'h05 with Overflow = 0 -> ResultadoLatched = 8'h05 and Blank = 0 next cycle, staying 0.
6. Force the state register to 11 (bench force) -> Base = 00 the following cycle, BaseLed = 001.

Source files
------------

// File: rtl/rpn_display_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rpn_display_ctrl_pkg
// Shared constants for the RPN ALU result display path.
//   base_e        : display base select encoding (DEC/HEX/OCT). The display
//                   muxes decode the same values.
//   *_DEFAULT     : default timing parameters for a 50 MHz system clock.
//   base_led()    : one-hot indicator decode of a base select value.
//   cnt_width()   : counter width able to hold 0 .. n-1 (at least 1 bit).
// ---------------------------------------------------------------------------
package rpn_display_ctrl_pkg;

  typedef enum logic [1:0] {
    BASE_DEC = 2'b00,
    BASE_HEX = 2'b01,
    BASE_OCT = 2'b10
  } base_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;    // 10 ms
  localparam int AUTO_PERIOD_DEFAULT     = 50000000;  // 1 s
  localparam int BLINK_PERIOD_DEFAULT    = 25000000;  // 0.5 s half-period

  // [0] = Dec, [1] = Hex, [2] = Oct. The unused code shows Dec, matching the
  // state the FSM recovers to.
  function automatic logic [2:0] base_led(input logic [1:0] base);
    logic [2:0] led;
    case (base)
      BASE_HEX: led = 3'b010;
      BASE_OCT: led = 3'b100;
      default:  led = 3'b001;
    endcase
    return led;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rpn_debounce.sv
// ---------------------------------------------------------------------------
// rpn_debounce
// Synchronizes an asynchronous, active-low pushbutton and debounces it.
//   Clock   : system clock
//   Resetn  : asynchronous reset, active-low
//   raw_i   : raw button level (pressed = 0), asynchronous to Clock
//   level_o : debounced level (1 = released)
//   fall_o  : one-cycle pulse, asserted in the cycle after the debounced
//             level goes 1 -> 0 (aligned with level_o falling)
// The debounced level follows the synchronized input only after the two have
// differed for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample
// restarts the count.
// ---------------------------------------------------------------------------
module rpn_debounce
  import rpn_display_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronizer and debounced level come out of reset as "released" so a
  // reset never manufactures a press.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds the number of consecutive earlier mismatches; the current
  // mismatch completes the run when cnt_q already reads DEBOUNCE_CYCLES-1.
  always_comb begin
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q;
        fall_d  = ~sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/rpn_display_ctrl.sv
// ---------------------------------------------------------------------------
// rpn_display_ctrl
// Sequencing controller for the 3-digit result display of the 8-bit RPN ALU.
//   Clock            : system clock
//   Resetn           : asynchronous reset, active-low
//   Resultado        : ALU result
//   ResultadoValido  : one-cycle strobe qualifying Resultado / Overflow
//   Overflow         : ALU overflow flag
//   BotaoBase        : raw base pushbutton, active-low, asynchronous
//   ModoAuto         : raw slide switch, 1 = auto-rotate the base
//   ResultadoLatched : held result for the display converters
//   Base             : base select (00 Dec, 01 Hex, 10 Oct)
//   BaseLed          : one-hot base indicator
//   Blank            : 1 = display path forces all segments off
// ---------------------------------------------------------------------------
module rpn_display_ctrl
  import rpn_display_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int AUTO_PERIOD     = AUTO_PERIOD_DEFAULT,
  parameter int BLINK_PERIOD    = BLINK_PERIOD_DEFAULT
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [7:0] Resultado,
  input  logic       ResultadoValido,
  input  logic       Overflow,
  input  logic       BotaoBase,
  input  logic       ModoAuto,
  output logic [7:0] ResultadoLatched,
  output logic [1:0] Base,
  output logic [2:0] BaseLed,
  output logic       Blank
);

  localparam int AW = cnt_width(AUTO_PERIOD);
  localparam int BW = cnt_width(BLINK_PERIOD);

  // ------------------------------------------------------------------ inputs
  logic press_pulse;
  logic btn_level_unused;  // debounced level, kept for probing only

  rpn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .Clock  (Clock),
    .Resetn (Resetn),
    .raw_i  (BotaoBase),
    .level_o(btn_level_unused),
    .fall_o (press_pulse)
  );

  // The slide switch has no bounce that matters at a 1 s rotate period, so it
  // is only synchronized.
  logic auto_meta_q, auto_sync_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      auto_meta_q <= 1'b1;
      auto_sync_q <= 1'b1;
    end else begin
      auto_meta_q <= ModoAuto;
      auto_sync_q <= auto_meta_q;
    end
  end

  // -------------------------------------------------------------- auto timer
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  logic          auto_tick;

  assign auto_tick = auto_sync_q && (auto_cnt_q == AW'(AUTO_PERIOD - 1));

  // A manual press restarts the full period so a tick never lands right
  // after the user chose a base.
  always_comb begin
    auto_cnt_d = auto_cnt_q + AW'(1);
    if (!auto_sync_q || press_pulse || auto_tick) begin
      auto_cnt_d = '0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) auto_cnt_q <= '0;
    else         auto_cnt_q <= auto_cnt_d;
  end

  // ---------------------------------------------------------------- base FSM
  base_e base_q, base_d;
  logic  advance;

  // A press and a tick in the same cycle collapse into one advance.
  assign advance = press_pulse | auto_tick;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) base_q <= BASE_DEC;
    else         base_q <= base_d;
  end

  always_comb begin
    base_d = base_q;
    case (base_q)
      BASE_DEC: if (advance) base_d = BASE_HEX;
      BASE_HEX: if (advance) base_d = BASE_OCT;
      BASE_OCT: if (advance) base_d = BASE_DEC;
      default:  base_d = BASE_DEC;  // illegal 11 recovers unconditionally
    endcase
  end

  always_comb begin
    Base    = base_q;
    BaseLed = base_led(base_q);
  end

  // ------------------------------------------------- result latch and blink
  logic [7:0]    result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          blank_q, blank_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  // Every strobe restarts the blink phase so a fresh overflow always shows
  // a full lit half-period before the first blank.
  always_comb begin
    result_d    = result_q;
    ovf_d       = ovf_q;
    blank_d     = 1'b0;
    blink_cnt_d = '0;
    if (ResultadoValido) begin
      result_d = Resultado;
      ovf_d    = Overflow;
    end else if (ovf_q) begin
      if (blink_cnt_q == BW'(BLINK_PERIOD - 1)) begin
        blank_d = ~blank_q;
      end else begin
        blank_d     = blank_q;
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      result_q    <= '0;
      ovf_q       <= 1'b0;
      blank_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      blank_q     <= blank_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign ResultadoLatched = result_q;
  assign Blank            = blank_q;

endmodule

// File: tb/tb_rpn_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rpn_display_ctrl
// Directed scenarios followed by a random phase. A behavioural model tracks
// what the display should show from the observable rules: input samples seen
// two cycles late, a base that changes when the last DEBOUNCE_CYCLES samples
// all disagree with the accepted level, a rotating base index, and a blank
// phase derived from the time elapsed since the last overflow strobe.
// ---------------------------------------------------------------------------
module tb_rpn_display_ctrl;

  localparam int DB = 4;
  localparam int AP = 10;
  localparam int BP = 3;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b1;
  logic [7:0] Resultado = 8'h00;
  logic       ResultadoValido = 1'b0;
  logic       Overflow = 1'b0;
  logic       BotaoBase = 1'b1;
  logic       ModoAuto = 1'b0;
  logic [7:0] ResultadoLatched;
  logic [1:0] Base;
  logic [2:0] BaseLed;
  logic       Blank;

  rpn_display_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_PERIOD    (AP),
    .BLINK_PERIOD   (BP)
  ) u_dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .Resultado       (Resultado),
    .ResultadoValido (ResultadoValido),
    .Overflow        (Overflow),
    .BotaoBase       (BotaoBase),
    .ModoAuto        (ModoAuto),
    .ResultadoLatched(ResultadoLatched),
    .Base            (Base),
    .BaseLed         (BaseLed),
    .Blank           (Blank)
  );

  always #5 Clock = ~Clock;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // ------------------------------------------------------------------ model
  int         k;            // clock edges since reset release
  bit         btn_hist[$];  // raw button level applied before each edge
  bit         modo_hist[$];
  bit         m_level;      // accepted button level
  bit         m_press_pend; // press accepted on the previous edge
  int         m_auto;       // cycles counted toward the next auto advance
  int         m_base;       // 0 Dec, 1 Hex, 2 Oct (3 only when forced)
  logic [7:0] m_lat;
  bit         m_ovf;
  int         m_strobe;     // edge at which the last strobe was captured
  bit         skip_base = 1'b0;

  // Logic acting on edge e sees the raw level applied two edges earlier;
  // before that the synchronizer still holds its released/idle reset value.
  function automatic bit btn_seen(input int e);
    int i = e - 3;
    if (i < 0) return 1'b1;
    return btn_hist[i];
  endfunction

  function automatic bit modo_seen(input int e);
    int i = e - 3;
    if (i < 0) return 1'b1;
    return modo_hist[i];
  endfunction

  function automatic bit m_blank();
    return m_ovf && ((((k - m_strobe) / BP) % 2) == 1);
  endfunction

  task automatic model_reset();
    k = 0;
    btn_hist.delete();
    modo_hist.delete();
    m_level = 1'b1;
    m_press_pend = 1'b0;
    m_auto = 0;
    m_base = 0;
    m_lat = 8'h00;
    m_ovf = 1'b0;
    m_strobe = 0;
  endtask

  task automatic model_edge();
    bit all_diff;
    bit adv;
    bit msync;
    btn_hist.push_back(BotaoBase);
    modo_hist.push_back(ModoAuto);
    k++;
    msync = modo_seen(k);
    adv = m_press_pend || (msync && (m_auto == AP - 1));
    if (!msync || m_press_pend || (m_auto == AP - 1)) m_auto = 0;
    else m_auto++;
    all_diff = 1'b1;
    for (int j = 0; j < DB; j++) begin
      if (btn_seen(k - j) == m_level) all_diff = 1'b0;
    end
    m_press_pend = 1'b0;
    if (all_diff) begin
      m_level = !m_level;
      m_press_pend = (m_level == 1'b0);
    end
    if (m_base == 3) m_base = 0;
    else if (adv) m_base = (m_base + 1) % 3;
    if (ResultadoValido) begin
      m_lat = Resultado;
      m_ovf = Overflow;
      m_strobe = k;
    end
  endtask

  // ----------------------------------------------------------------- checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("latched", 32'(ResultadoLatched), 32'(m_lat));
    if (!skip_base) begin
      chk("base", 32'(Base), 32'(m_base));
      chk("baseled", 32'(BaseLed), 32'(1 << m_base));
    end
    chk("blank", 32'(Blank), 32'(m_blank()));
  endtask

  // Inputs are changed only at the falling edge; each step models the next
  // rising edge and checks the DUT at the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      model_edge();
      @(posedge Clock);
      @(negedge Clock);
      check_all();
    end
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    bit bounce_pat [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int btn_run;
    int modo_run;

    // Reset is asynchronous: outputs must be at reset values before any edge.
    #3 Resetn = 1'b0;
    #1;
    chk("rst_base", 32'(Base), 32'h0);
    chk("rst_baseled", 32'(BaseLed), 32'h1);
    chk("rst_blank", 32'(Blank), 32'h0);
    chk("rst_latched", 32'(ResultadoLatched), 32'h0);
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    model_reset();
    step(3);

    // Three clean presses: Dec -> Hex -> Oct -> Dec.
    for (int p = 0; p < 3; p++) begin
      BotaoBase = 1'b0;
      step(5);
      chk("press_not_yet", 32'(Base), 32'(p));
      step(3);
      chk("press_advanced", 32'(Base), 32'((p + 1) % 3));
      BotaoBase = 1'b1;
      step(8);
    end
    chk("press_release_noevent", 32'(Base), 32'h0);

    // Bouncy press gives exactly one advance.
    for (int i = 0; i < 8; i++) begin
      BotaoBase = bounce_pat[i];
      step(1);
    end
    BotaoBase = 1'b0;
    step(10);
    BotaoBase = 1'b1;
    step(10);
    chk("bounce_one_adv", 32'(Base), 32'h1);

    // A 3-cycle glitch is shorter than the debounce window.
    BotaoBase = 1'b0;
    step(3);
    BotaoBase = 1'b1;
    step(10);
    chk("glitch_no_adv", 32'(Base), 32'h1);

    // Auto rotate: advances every AP cycles.
    ModoAuto = 1'b1;
    step(12);
    chk("auto_tick1", 32'(Base), 32'h2);
    step(10);
    chk("auto_tick2", 32'(Base), 32'h0);
    step(10);
    chk("auto_tick3", 32'(Base), 32'h1);
    step(3);
    ModoAuto = 1'b0;
    step(6);
    chk("auto_off_hold", 32'(Base), 32'h1);

    // Press accepted in the same cycle as a tick: one advance, fresh period.
    ModoAuto = 1'b1;
    step(5);
    BotaoBase = 1'b0;
    step(6);
    chk("coinc_before", 32'(Base), 32'h1);
    step(1);
    chk("coinc_single_adv", 32'(Base), 32'h2);
    step(9);
    chk("coinc_no_early_tick", 32'(Base), 32'h2);
    step(1);
    chk("coinc_next_tick", 32'(Base), 32'h0);
    ModoAuto = 1'b0;
    BotaoBase = 1'b1;
    step(10);

    // Overflow result blinks; a clean result stops it.
    Resultado = 8'hC8;
    Overflow = 1'b1;
    ResultadoValido = 1'b1;
    step(1);
    ResultadoValido = 1'b0;
    Overflow = 1'b0;
    chk("ovf_latched", 32'(ResultadoLatched), 32'hC8);
    chk("ovf_blank_lit", 32'(Blank), 32'h0);
    step(2);
    chk("ovf_blank_still_lit", 32'(Blank), 32'h0);
    step(1);
    chk("ovf_blank_on", 32'(Blank), 32'h1);
    step(3);
    chk("ovf_blank_off", 32'(Blank), 32'h0);
    step(3);
    chk("ovf_blank_on2", 32'(Blank), 32'h1);
    Resultado = 8'h05;
    ResultadoValido = 1'b1;
    step(1);
    ResultadoValido = 1'b0;
    chk("clean_latched", 32'(ResultadoLatched), 32'h05);
    chk("clean_blank", 32'(Blank), 32'h0);
    step(7);
    chk("clean_blank_stays", 32'(Blank), 32'h0);

    // Illegal state 11 recovers to Dec.
    force u_dut.base_q = rpn_display_ctrl_pkg::base_e'(2'b11);
    #1;
    chk("forced_state_seen", 32'(Base), 32'h3);
    skip_base = 1'b1;
    m_base = 3;
    step(1);
    skip_base = 1'b0;
    release u_dut.base_q;
    step(1);
    chk("illegal_recover_base", 32'(Base), 32'h0);
    chk("illegal_recover_led", 32'(BaseLed), 32'h1);

    // Reset in the middle of a debounce, auto count and blink.
    Resultado = 8'hAA;
    Overflow = 1'b1;
    ResultadoValido = 1'b1;
    BotaoBase = 1'b0;
    ModoAuto = 1'b1;
    step(1);
    ResultadoValido = 1'b0;
    step(13);
    #2 Resetn = 1'b0;
    #1;
    chk("midrst_base", 32'(Base), 32'h0);
    chk("midrst_baseled", 32'(BaseLed), 32'h1);
    chk("midrst_blank", 32'(Blank), 32'h0);
    chk("midrst_latched", 32'(ResultadoLatched), 32'h0);
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    model_reset();
    step(20);

    // Random phase against the model.
    btn_run = 0;
    modo_run = 0;
    for (int c = 0; c < 900; c++) begin
      if (btn_run == 0) begin
        BotaoBase = ~BotaoBase;
        btn_run = int'($urandom_range(1, 9));
      end
      btn_run--;
      if (modo_run == 0) begin
        ModoAuto = ($urandom_range(0, 2) == 0);
        modo_run = int'($urandom_range(5, 40));
      end
      modo_run--;
      ResultadoValido = ($urandom_range(0, 15) == 0);
      Resultado = 8'($urandom);
      Overflow = 1'($urandom_range(0, 1));
      step(1);
    end
    ResultadoValido = 1'b0;
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
